bus_demux_1to8: RTL and testbench
=================================

// Module: bus_demux_1to8
// PURPOSE
//  Routes one initiator bus request to one of 8 peripheral target ports and returns the selected
//  target's read data/response; the distribute-and-collect counterpart of the 8:1 result select.
//  Sits between the RV32I core load/store unit and the microcontroller peripherals (GPIO, timer, UART...).
//  Registered request, per-target ready handshake, timeout error so a dead target never hangs the core.
// PARAMETERS
//  DATA_W   32  data bus width
//  ADDR_W   32  address bus width
//  SEL_LSB  28  target index = M_ADDR[SEL_LSB+2:SEL_LSB]
//  TIMEOUT  15  max ACCESS cycles waiting for S_READY before error (>=1, counter width $clog2(TIMEOUT+1))
// PORTS
//  CLK      in   1          clock, rising edge
//  RST      in   1          reset, asynchronous, active-low
//  M_VALID  in   1          initiator request valid; held high with stable addr/data until M_READY
//  M_WE     in   1          1 = write, 0 = read
//  M_ADDR   in   ADDR_W     request address
//  M_WDATA  in   DATA_W     write data
//  M_READY  out  1          one-cycle completion pulse
//  M_RDATA  out  DATA_W     read data, valid while M_READY=1
//  M_ERR    out  1          timeout flag, valid while M_READY=1
//  S_SEL    out  8          one-hot target select, held for whole access
//  S_WE     out  1          registered copy of M_WE
//  S_ADDR   out  ADDR_W     registered copy of M_ADDR (full address passed through)
//  S_WDATA  out  DATA_W     registered copy of M_WDATA
//  S_RDATA  in   8*DATA_W   target read data, target k at [k*DATA_W +: DATA_W]
//  S_READY  in   8          target k completes access when S_READY[k]=1 while S_SEL[k]=1
// BEHAVIOUR
//  Reset (RST=0, async): state IDLE; all outputs 0; timeout counter 0.
//  FSM states IDLE, ACCESS, DONE:
//   IDLE:   M_VALID=1 -> latch M_WE/M_ADDR/M_WDATA into S_*, S_SEL <= onehot(idx), cnt<=0, go ACCESS.
//   ACCESS: S_READY[idx]=1 -> M_RDATA <= S_RDATA slice idx (writes: 0), M_ERR<=0, S_SEL<=0, go DONE.
//           else cnt==TIMEOUT-1 -> M_RDATA<=0, M_ERR<=1, S_SEL<=0, go DONE; else cnt<=cnt+1.
//   DONE:   M_READY=1 for exactly this cycle; go IDLE; M_RDATA/M_ERR then cleared to 0.
//  Latency: M_VALID in IDLE at edge n -> S_SEL high from n+1; ready seen at edge n+1 -> M_READY in n+2.
//  Minimum 3 cycles per transaction; M_VALID during ACCESS/DONE ignored (no new capture until IDLE).
//  Only S_READY[idx] is observed; ready on unselected targets ignored; ready and timeout in same cycle
//  -> ready wins (M_ERR=0).
//  Timeout: exactly TIMEOUT ACCESS cycles without ready -> error completion; counter never wraps.
//  S_WE/S_ADDR/S_WDATA hold last values after completion; only S_SEL returns to 0.
//  Reset mid-ACCESS: S_SEL drops to 0 immediately, no M_READY issued, transaction abandoned.
//  M_ADDR bits outside the select field do not affect routing.
// STRUCTURE
//  Shared package: state encodings (IDLE/ACCESS/DONE), NUM_TARGETS=8, target index width 3.
//  Sub-module: decoder_3to8 (combinational one-hot decode of the 3-bit index, registered in parent).
//  Parent holds FSM, request/response registers, timeout counter, read-data select.
// TESTING
//  Reset: RST=0 mid-run -> all outputs 0 asynchronously, FSM IDLE; RST release -> no spurious M_READY.
//  Read: M_ADDR=0x3000_0010, S_READY[3]=1 next cycle, S_RDATA slice3=0xDEADBEEF -> S_SEL=8'h08,
//   M_READY pulse 2 cycles after request, M_RDATA=0xDEADBEEF, M_ERR=0.
//  Write: M_WE=1, M_ADDR=0x7000_0004, M_WDATA=0x1234_5678, target 7 ready after 4 cycles ->
//   S_SEL=8'h80, S_WDATA=0x12345678, M_READY once, M_RDATA=0.
//  Timeout: target 5 never ready, TIMEOUT=15 -> S_SEL=8'h20 for 15 cycles, M_READY with M_ERR=1, M_RDATA=0.
//  Isolation: target 2 selected, S_READY=8'hFB (all but 2) -> no completion until S_READY[2] asserted.
//  Sweep: back-to-back requests to idx 0..7 with M_VALID held -> one completion per request, correct
//   one-hot each, no request captured during ACCESS/DONE.

Source files
------------

// File: rtl/bus_demux_1to8_pkg.sv
// Shared definitions for the 1-to-8 peripheral bus demultiplexer:
// FSM state encoding and target-count constants.
package bus_demux_1to8_pkg;

   localparam int NUM_TARGETS = 8;
   localparam int IDX_W       = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/bus_demux_1to8_decoder.sv
// Combinational 3-to-8 one-hot decoder; the parent registers the result
// into its target-select output.
module decoder_3to8
   import bus_demux_1to8_pkg::*;
(
   input  logic [IDX_W-1:0]       i_idx,
   output logic [NUM_TARGETS-1:0] o_onehot
);

   // Index to one-hot target select
   always_comb begin
      o_onehot = 8'h00;
      case (i_idx)
         3'd0:    o_onehot = 8'h01;
         3'd1:    o_onehot = 8'h02;
         3'd2:    o_onehot = 8'h04;
         3'd3:    o_onehot = 8'h08;
         3'd4:    o_onehot = 8'h10;
         3'd5:    o_onehot = 8'h20;
         3'd6:    o_onehot = 8'h40;
         3'd7:    o_onehot = 8'h80;
         default: o_onehot = 8'h00;
      endcase
   end

endmodule

// File: rtl/bus_demux_1to8.sv
// Routes one initiator request to one of 8 peripheral targets, collects the
// selected target's read data, and errors out if the target never answers.
module bus_demux_1to8
   import bus_demux_1to8_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int SEL_LSB = 28,
   parameter int TIMEOUT = 15
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          M_VALID,
   input  logic                          M_WE,
   input  logic [ADDR_W-1:0]             M_ADDR,
   input  logic [DATA_W-1:0]             M_WDATA,
   output logic                          M_READY,
   output logic [DATA_W-1:0]             M_RDATA,
   output logic                          M_ERR,
   output logic [NUM_TARGETS-1:0]        S_SEL,
   output logic                          S_WE,
   output logic [ADDR_W-1:0]             S_ADDR,
   output logic [DATA_W-1:0]             S_WDATA,
   input  logic [NUM_TARGETS*DATA_W-1:0] S_RDATA,
   input  logic [NUM_TARGETS-1:0]        S_READY
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e                   r_state;
   logic [CNT_W-1:0]         r_cnt;
   logic [IDX_W-1:0]         r_idx;

   logic [IDX_W-1:0]         w_idx;
   logic [NUM_TARGETS-1:0]   w_onehot;
   logic [DATA_W-1:0]        w_rdata_sel;
   logic                     w_tgt_ready;

   assign w_idx       = M_ADDR[SEL_LSB+IDX_W-1:SEL_LSB];
   assign w_rdata_sel = S_RDATA[r_idx*DATA_W +: DATA_W];
   // Only the latched target's ready is honoured; others are ignored
   assign w_tgt_ready = S_READY[r_idx];

   decoder_3to8 u_decoder (
      .i_idx    (w_idx),
      .o_onehot (w_onehot)
   );

   // Transaction FSM with registered request, response and timeout counter
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= ST_IDLE;
         r_cnt   <= {CNT_W{1'b0}};
         r_idx   <= {IDX_W{1'b0}};
         M_READY <= 1'b0;
         M_RDATA <= {DATA_W{1'b0}};
         M_ERR   <= 1'b0;
         S_SEL   <= {NUM_TARGETS{1'b0}};
         S_WE    <= 1'b0;
         S_ADDR  <= {ADDR_W{1'b0}};
         S_WDATA <= {DATA_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               M_READY <= 1'b0;
               M_RDATA <= {DATA_W{1'b0}};
               M_ERR   <= 1'b0;
               if (M_VALID) begin
                  S_WE    <= M_WE;
                  S_ADDR  <= M_ADDR;
                  S_WDATA <= M_WDATA;
                  S_SEL   <= w_onehot;
                  r_idx   <= w_idx;
                  r_cnt   <= {CNT_W{1'b0}};
                  r_state <= ST_ACCESS;
               end else begin
                  r_state <= ST_IDLE;
               end
            end

            ST_ACCESS: begin
               // Ready is checked before the timeout so a same-cycle answer wins
               if (w_tgt_ready) begin
                  M_RDATA <= S_WE ? {DATA_W{1'b0}} : w_rdata_sel;
                  M_ERR   <= 1'b0;
                  M_READY <= 1'b1;
                  S_SEL   <= {NUM_TARGETS{1'b0}};
                  r_state <= ST_DONE;
               end else if (r_cnt == CNT_LAST) begin
                  M_RDATA <= {DATA_W{1'b0}};
                  M_ERR   <= 1'b1;
                  M_READY <= 1'b1;
                  S_SEL   <= {NUM_TARGETS{1'b0}};
                  r_state <= ST_DONE;
               end else begin
                  r_cnt   <= r_cnt + CNT_ONE;
                  r_state <= ST_ACCESS;
               end
            end

            ST_DONE: begin
               M_READY <= 1'b0;
               M_RDATA <= {DATA_W{1'b0}};
               M_ERR   <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               M_READY <= 1'b0;
               M_RDATA <= {DATA_W{1'b0}};
               M_ERR   <= 1'b0;
               S_SEL   <= {NUM_TARGETS{1'b0}};
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_demux_1to8.sv
// Directed-vector bench for bus_demux_1to8: reset, read, write, timeout,
// target isolation, ready-vs-timeout race, back-to-back sweep, mid-access reset.
module tb_bus_demux_1to8;

   logic          CLK;
   logic          RST;
   logic          M_VALID;
   logic          M_WE;
   logic [31:0]   M_ADDR;
   logic [31:0]   M_WDATA;
   logic          M_READY;
   logic [31:0]   M_RDATA;
   logic          M_ERR;
   logic [7:0]    S_SEL;
   logic          S_WE;
   logic [31:0]   S_ADDR;
   logic [31:0]   S_WDATA;
   logic [255:0]  S_RDATA;
   logic [7:0]    S_READY;

   int n_vec = 0;
   int n_err = 0;

   bus_demux_1to8 #(
      .DATA_W  (32),
      .ADDR_W  (32),
      .SEL_LSB (28),
      .TIMEOUT (15)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .M_VALID (M_VALID),
      .M_WE    (M_WE),
      .M_ADDR  (M_ADDR),
      .M_WDATA (M_WDATA),
      .M_READY (M_READY),
      .M_RDATA (M_RDATA),
      .M_ERR   (M_ERR),
      .S_SEL   (S_SEL),
      .S_WE    (S_WE),
      .S_ADDR  (S_ADDR),
      .S_WDATA (S_WDATA),
      .S_RDATA (S_RDATA),
      .S_READY (S_READY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ".ready"}, 64'(M_READY), 64'd0);
      chk({tag, ".rdata"}, 64'(M_RDATA), 64'd0);
      chk({tag, ".err"},   64'(M_ERR),   64'd0);
      chk({tag, ".sel"},   64'(S_SEL),   64'd0);
   endtask

   initial begin
      int  hi;
      int  pulses;
      bit  done;
      logic [7:0]  exp_sel;
      logic [31:0] exp_data;

      RST     = 1'b0;
      M_VALID = 1'b0;
      M_WE    = 1'b0;
      M_ADDR  = 32'h0;
      M_WDATA = 32'h0;
      S_RDATA = 256'h0;
      S_READY = 8'h00;

      // ---------------- reset state
      @(negedge CLK);
      chk_idle_outputs("rst");
      chk("rst.we",    64'(S_WE),    64'd0);
      chk("rst.addr",  64'(S_ADDR),  64'd0);
      chk("rst.wdata", 64'(S_WDATA), 64'd0);
      tick();
      RST = 1'b1;
      tick();
      tick();
      chk("rst.release_ready", 64'(M_READY), 64'd0);

      // ---------------- read from target 3
      S_RDATA[3*32 +: 32] = 32'hDEADBEEF;
      S_RDATA[4*32 +: 32] = 32'h44444444;
      M_ADDR  = 32'h3000_0010;
      M_WE    = 1'b0;
      M_VALID = 1'b1;
      tick();
      chk("rd.sel",   64'(S_SEL),   64'h08);
      chk("rd.addr",  64'(S_ADDR),  64'h3000_0010);
      chk("rd.ready0", 64'(M_READY), 64'd0);
      S_READY = 8'h08;
      tick();
      chk("rd.ready", 64'(M_READY), 64'd1);
      chk("rd.rdata", 64'(M_RDATA), 64'hDEADBEEF);
      chk("rd.err",   64'(M_ERR),   64'd0);
      chk("rd.sel_off", 64'(S_SEL), 64'h00);
      S_READY = 8'h00;
      M_VALID = 1'b0;
      tick();
      chk_idle_outputs("rd.after");

      // ---------------- write to target 7, ready after 4 cycles
      S_RDATA[7*32 +: 32] = 32'hCAFEF00D;
      M_WE    = 1'b1;
      M_ADDR  = 32'h7000_0004;
      M_WDATA = 32'h1234_5678;
      M_VALID = 1'b1;
      tick();
      chk("wr.sel",   64'(S_SEL),   64'h80);
      chk("wr.wdata", 64'(S_WDATA), 64'h1234_5678);
      chk("wr.we",    64'(S_WE),    64'd1);
      pulses = 0;
      for (int c = 0; c < 3; c++) begin
         if (M_READY) pulses++;
         tick();
      end
      S_READY = 8'h80;
      tick();
      chk("wr.early_ready", 64'(pulses), 64'd0);
      chk("wr.ready", 64'(M_READY), 64'd1);
      chk("wr.rdata", 64'(M_RDATA), 64'd0);
      chk("wr.err",   64'(M_ERR),   64'd0);
      S_READY = 8'h00;
      M_VALID = 1'b0;
      M_WE    = 1'b0;
      tick();
      chk("wr.once",       64'(M_READY), 64'd0);
      chk("wr.hold_wdata", 64'(S_WDATA), 64'h1234_5678);
      chk("wr.hold_addr",  64'(S_ADDR),  64'h7000_0004);

      // ---------------- timeout on target 5 (upper/low addr bits outside field)
      S_RDATA[5*32 +: 32] = 32'h55AA55AA;
      M_ADDR  = 32'hD123_4567;
      M_VALID = 1'b1;
      tick();
      hi   = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (S_SEL == 8'h20) hi++;
         if (M_READY) done = 1'b1;
         else tick();
      end
      chk("to.done",  64'(done),    64'd1);
      chk("to.sel_cycles", 64'(hi), 64'd15);
      chk("to.err",   64'(M_ERR),   64'd1);
      chk("to.rdata", 64'(M_RDATA), 64'd0);
      M_VALID = 1'b0;
      tick();
      chk_idle_outputs("to.after");

      // ---------------- isolation: target 2 ignores other readies
      S_RDATA[2*32 +: 32] = 32'h2222_ABCD;
      M_ADDR  = 32'h2000_0100;
      M_VALID = 1'b1;
      tick();
      chk("iso.sel", 64'(S_SEL), 64'h04);
      S_READY = 8'hFB;
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (M_READY) pulses++;
      end
      chk("iso.no_done", 64'(pulses), 64'd0);
      chk("iso.sel_held", 64'(S_SEL), 64'h04);
      S_READY = 8'hFF;
      tick();
      chk("iso.ready", 64'(M_READY), 64'd1);
      chk("iso.rdata", 64'(M_RDATA), 64'h2222_ABCD);
      S_READY = 8'h00;
      M_VALID = 1'b0;
      tick();

      // ---------------- ready arrives in the final timeout cycle: ready wins
      S_RDATA[1*32 +: 32] = 32'h1111_0001;
      M_ADDR  = 32'h1000_0000;
      M_VALID = 1'b1;
      tick();
      for (int c = 0; c < 14; c++) tick();
      chk("race.pending", 64'(M_READY), 64'd0);
      S_READY = 8'h02;
      tick();
      chk("race.ready", 64'(M_READY), 64'd1);
      chk("race.err",   64'(M_ERR),   64'd0);
      chk("race.rdata", 64'(M_RDATA), 64'h1111_0001);
      S_READY = 8'h00;
      M_VALID = 1'b0;
      tick();

      // ---------------- sweep idx 0..7 with M_VALID held and all targets ready
      for (int k = 0; k < 8; k++) S_RDATA[k*32 +: 32] = 32'hA0A0_0000 | 32'(k);
      S_READY = 8'hFF;
      M_VALID = 1'b1;
      pulses  = 0;
      for (int k = 0; k < 8; k++) begin
         exp_sel  = 8'h01 << k;
         exp_data = 32'hA0A0_0000 | 32'(k);
         M_ADDR   = (32'(k) << 28) | 32'(k * 4);
         tick();
         chk($sformatf("sw%0d.sel", k), 64'(S_SEL), 64'(exp_sel));
         tick();
         if (M_READY) pulses++;
         chk($sformatf("sw%0d.rdata", k), 64'(M_RDATA), 64'(exp_data));
         // change the request during DONE; it must not be captured until IDLE
         M_ADDR = 32'h6000_0000;
         tick();
         chk($sformatf("sw%0d.no_cap", k), 64'(S_SEL), 64'h00);
         chk($sformatf("sw%0d.addr_held", k), 64'(S_ADDR), 64'((32'(k) << 28) | 32'(k * 4)));
      end
      chk("sw.completions", 64'(pulses), 64'd8);
      M_VALID = 1'b0;
      S_READY = 8'h00;
      tick();
      tick();

      // ---------------- reset in the middle of an access
      M_ADDR  = 32'h6000_0000;
      M_VALID = 1'b1;
      tick();
      chk("mr.sel", 64'(S_SEL), 64'h40);
      #2;
      RST = 1'b0;
      #1;
      chk("mr.sel_async",  64'(S_SEL),  64'h00);
      chk("mr.addr_async", 64'(S_ADDR), 64'h00);
      M_VALID = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (M_READY) pulses++;
      end
      chk("mr.no_ready", 64'(pulses), 64'd0);
      chk("mr.sel_idle", 64'(S_SEL),  64'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
